// File: rtl/bkm_iter_ctrl.sv
// bkm_iter_ctrl: iteration sequencer for one folded bkm_step instance.
// Accepts an operation, prefetches LUT entry 0, steps bkm_step through
// iterations 0..n_last, then holds the result until the consumer takes it.
// Optional build macro: BKM_ITER_CTRL_ABORT_EN adds an 'abort' input that
// drops the in-flight operation back to IDLE without issuing out_valid.
module bkm_iter_ctrl #(
    parameter int LOG2N = 3
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             enable,
`ifdef BKM_ITER_CTRL_ABORT_EN
    input  logic             abort,
`endif
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_mode,
    input  logic [1:0]       in_format,
    input  logic [LOG2N-1:0] in_n_last,
    output logic             step_mode,
    output logic [1:0]       step_format,
    output logic [LOG2N-1:0] step_n,
    output logic             step_en,
    output logic             step_load,
    output logic [LOG2N-1:0] lut_addr,
    output logic             lut_rd,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy
);

    typedef enum logic [1:0] {IDLE, PREF, ITER, DONE} state_t;

    state_t           state_q, state_d;
    logic [LOG2N-1:0] k_q, k_d;
    logic [LOG2N-1:0] nlast_q, nlast_d;
    logic             mode_q, mode_d;
    logic [1:0]       fmt_q, fmt_d;

    logic abort_w;
    logic kill;
    logic accept;
    logic is_last;

`ifdef BKM_ITER_CTRL_ABORT_EN
    assign abort_w = abort;
`else
    assign abort_w = 1'b0;
`endif

    // abort only matters while an operation is in flight and the block is enabled
    assign kill    = enable & abort_w & (state_q != IDLE);
    assign is_last = (k_q == nlast_q);
    assign in_ready = enable & ~abort_w &
                      ((state_q == IDLE) | ((state_q == DONE) & out_ready));
    assign accept  = in_valid & in_ready;

    // state, iteration counter and latched operation fields
    always_ff @(posedge clk) begin
        if (srst) begin
            state_q <= IDLE;
            k_q     <= '0;
            nlast_q <= '0;
            mode_q  <= 1'b0;
            fmt_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            nlast_q <= nlast_d;
            mode_q  <= mode_d;
            fmt_q   <= fmt_d;
        end
    end

    // next-state: everything freezes while enable is low
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        nlast_d = nlast_q;
        mode_d  = mode_q;
        fmt_d   = fmt_q;
        if (enable) begin
            case (state_q)
                IDLE: if (accept) state_d = PREF;
                PREF: begin
                    state_d = ITER;
                    k_d     = '0;
                end
                // last-iteration check comes before the increment, so k never wraps
                ITER: begin
                    if (is_last) state_d = DONE;
                    else         k_d     = k_q + LOG2N'(1);
                end
                DONE: if (out_ready) state_d = accept ? PREF : IDLE;
                default: state_d = IDLE;
            endcase
            if (accept) begin
                k_d     = '0;
                nlast_d = in_n_last;
                mode_d  = in_mode;
                fmt_d   = in_format;
            end
            if (kill) state_d = IDLE;
        end
    end

    // output decode: strobes are Moore outputs of the state, gated by enable/abort
    always_comb begin
        step_mode   = mode_q;
        step_format = fmt_q;
        step_n      = k_q;
        busy        = (state_q != IDLE) & ~kill;
        out_valid   = (state_q == DONE) & ~kill;
        step_en     = enable & ~kill & (state_q == ITER);
        step_load   = ~kill & (state_q == ITER) & (k_q == '0);
        lut_rd      = 1'b0;
        lut_addr    = '0;
        if (state_q == PREF) begin
            lut_rd = enable & ~kill;
        end else if ((state_q == ITER) && !is_last) begin
            lut_rd   = enable & ~kill;
            lut_addr = k_q + LOG2N'(1);
        end
    end

endmodule

// File: tb/tb_bkm_iter_ctrl.sv
// Bench for bkm_iter_ctrl: directed scenarios plus random traffic, with a
// cycle-count reference model checked against every output on each cycle.
module tb_bkm_iter_ctrl;

    localparam int LOG2N = 3;

    logic             clk = 1'b0;
    logic             srst = 1'b1;
    logic             enable = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic             in_mode = 1'b0;
    logic [1:0]       in_format = 2'd0;
    logic [LOG2N-1:0] in_n_last = '0;
    logic             step_mode;
    logic [1:0]       step_format;
    logic [LOG2N-1:0] step_n;
    logic             step_en;
    logic             step_load;
    logic [LOG2N-1:0] lut_addr;
    logic             lut_rd;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic             busy;
`ifdef BKM_ITER_CTRL_ABORT_EN
    logic             abort = 1'b0;
`endif

    bkm_iter_ctrl #(.LOG2N(LOG2N)) dut (
        .clk(clk), .srst(srst), .enable(enable),
`ifdef BKM_ITER_CTRL_ABORT_EN
        .abort(abort),
`endif
        .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
        .in_format(in_format), .in_n_last(in_n_last),
        .step_mode(step_mode), .step_format(step_format), .step_n(step_n),
        .step_en(step_en), .step_load(step_load), .lut_addr(lut_addr),
        .lut_rd(lut_rd), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: an operation is "c cycles since accept".
    // c=0 prefetch, c=1..nl+1 iteration c-1, c=nl+2 result held.
    bit m_act = 0;
    int m_c = 0, m_nl = 0, m_snh = 0, m_fmt = 0;
    bit m_mode = 0;

    always @(negedge clk) begin
        bit pref, iter, done, rd, rdy, acc;
        int kk, ea;
        pref = m_act && (m_c == 0);
        iter = m_act && (m_c >= 1) && (m_c <= m_nl + 1);
        done = m_act && (m_c == m_nl + 2);
        kk   = !m_act ? m_snh : (m_c == 0 ? 0 : ((m_c - 1 > m_nl) ? m_nl : m_c - 1));
        rd   = pref || (iter && (m_c - 1 < m_nl));
        ea   = (iter && (m_c - 1 < m_nl)) ? m_c : 0;
        rdy  = enable && (!m_act || (done && out_ready));
        chk("m_in_ready", in_ready, rdy);
        chk("m_busy", busy, m_act);
        chk("m_out_valid", out_valid, done);
        chk("m_step_en", step_en, enable && iter);
        chk("m_step_load", step_load, iter && (m_c == 1));
        chk("m_lut_rd", lut_rd, enable && rd);
        chk("m_lut_addr", lut_addr, ea);
        chk("m_step_n", step_n, kk);
        chk("m_step_mode", step_mode, m_mode);
        chk("m_step_format", step_format, m_fmt);
        // advance to the state after the coming posedge
        if (srst) begin
            m_act = 0; m_c = 0; m_nl = 0; m_snh = 0; m_mode = 0; m_fmt = 0;
        end else if (enable) begin
            acc = in_valid && rdy;
            if (m_act && done && out_ready) begin
                m_act = 0;
                m_snh = m_nl;
            end else if (m_act && !done) begin
                m_c++;
            end
            if (acc) begin
                m_act = 1; m_c = 0; m_nl = in_n_last; m_mode = in_mode; m_fmt = in_format;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One operation from IDLE; optional stall of sl cycles starting st cycles after accept.
    task automatic run_op(input int nl, input int st, input int sl, output int lat);
        int k;
        logic [LOG2N-1:0] pa;
        k = 0; pa = '0;
        in_n_last = nl[LOG2N-1:0];
        in_mode   = 1'($urandom);
        in_format = 2'($urandom);
        enable = 1; out_ready = 1; in_valid = 1;
        tick();
        in_valid = 0;
        lat = 0;
        while (!out_valid && lat < 60) begin
            tick();
            lat++;
            enable = !(st >= 0 && lat >= st && lat < st + sl);
            if (!enable) chk("stall_n", step_n, st - 1);
            if (step_en) begin
                chk("seq_n", step_n, k);
                chk("seq_load", step_load, k == 0);
                chk("lut_lead", pa, k);
                k++;
            end
            if (lut_rd) pa = lut_addr;
        end
        enable = 1;
        chk("ov_timeout", out_valid, 1);
        chk("iter_count", k, nl + 1);
    endtask

    initial begin
        int lat, acc;
        bit seen;
        // reset
        srst = 1; enable = 1;
        repeat (2) tick();
        chk("rst_busy", busy, 0);
        chk("rst_ov", out_valid, 0);
        chk("rst_en", step_en, 0);
        chk("rst_rd", lut_rd, 0);
        chk("rst_n", step_n, 0);
        srst = 0;
        tick();
        chk("rst_ready", in_ready, 1);

        // single ops: latency n_last+2, plus a 3-cycle stall at k=3
        run_op(7, -1, 0, lat);
        chk("lat7", lat, 9);
        tick();
        chk("ov_one_cycle", out_valid, 0);
        run_op(0, -1, 0, lat);
        chk("lat0", lat, 2);
        tick();
        run_op(7, 4, 3, lat);
        chk("lat_stall", lat, 12);
        tick();

        // back-to-back with n_last=0: one accept every 3 cycles
        acc = 0;
        in_n_last = 0; in_valid = 1; out_ready = 1;
        for (int i = 0; i < 30; i++) begin
            if (in_ready) acc++;
            tick();
        end
        chk("b2b_accepts", acc, 10);
        in_valid = 0;
        repeat (4) tick();

        // backpressure in DONE
        in_n_last = 2; in_valid = 1; out_ready = 0;
        tick();
        in_valid = 0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        chk("bp_lat", lat, 4);
        in_valid = 1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_ov", out_valid, 1);
            chk("bp_ready", in_ready, 0);
            chk("bp_en", step_en, 0);
        end
        in_valid = 0; out_ready = 1;
        tick();
        chk("bp_idle", busy, 0);

        // reset in the middle of iteration k=4
        in_n_last = 7; in_valid = 1;
        tick();
        in_valid = 0;
        repeat (5) tick();
        chk("mid_k4", step_n, 4);
        srst = 1;
        tick();
        srst = 0;
        chk("mid_idle", busy, 0);
        seen = 0;
        repeat (12) begin
            tick();
            if (out_valid) seen = 1;
        end
        chk("mid_no_ov", seen, 0);

        // random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            in_valid  = 1'($urandom);
            in_n_last = LOG2N'($urandom);
            in_mode   = 1'($urandom);
            in_format = 2'($urandom);
            out_ready = ($urandom % 4) != 0;
            enable    = ($urandom % 8) != 0;
            srst      = ($urandom % 100) == 0;
            tick();
        end
        srst = 0; in_valid = 0; enable = 1;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
